// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the 64-point DIF FFT sequencer.
package fft_pkg;

    localparam int LOG2N   = 6;
    localparam int N       = 1 << LOG2N;
    localparam int ADDR_W  = LOG2N;
    localparam int TW_W    = LOG2N - 1;
    localparam int STAGE_W = 3;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        DRAIN,
        UNLOAD
    } state_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int k = 0; k < ADDR_W; k++) begin
            r[k] = a[ADDR_W-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address generator: walks stage/i/j so that i is the outer loop and j
// steps by the group span m, producing operand addresses and the twiddle index.
module fft_bf_addr_gen
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    input  logic                nextStage,
    output logic [ADDR_W-1:0]   addrA,
    output logic [ADDR_W-1:0]   addrB,
    output logic [TW_W-1:0]     twIdx,
    output logic [STAGE_W-1:0]  stage,
    output logic                lastInStage
);

    localparam logic [ADDR_W:0] N_EXT = (ADDR_W+1)'(N);

    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [ADDR_W-1:0]  i_q, i_d;
    logic [ADDR_W-1:0]  j_q, j_d;
    logic [ADDR_W:0]    span;
    logic [ADDR_W:0]    half;
    logic [ADDR_W:0]    jNext;
    logic [ADDR_W:0]    iNext;
    logic [ADDR_W-1:0]  twFull;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            stage_q <= stage_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        span        = N_EXT >> stage_q;
        half        = span >> 1;
        jNext       = {1'b0, j_q} + span;
        iNext       = {1'b0, i_q} + (ADDR_W+1)'(1);
        twFull      = i_q << stage_q;
        lastInStage = (jNext >= N_EXT) && (iNext >= half);

        stage_d = stage_q;
        i_d     = i_q;
        j_d     = j_q;
        if (clear) begin
            stage_d = '0;
            i_d     = '0;
            j_d     = '0;
        end else if (nextStage) begin
            stage_d = stage_q + STAGE_W'(1);
            i_d     = '0;
            j_d     = '0;
        end else if (advance && !lastInStage) begin
            // Inner j loop first; when the group is exhausted restart at the next i.
            if (jNext < N_EXT) begin
                j_d = jNext[ADDR_W-1:0];
            end else begin
                i_d = iNext[ADDR_W-1:0];
                j_d = iNext[ADDR_W-1:0];
            end
        end
    end

    assign addrA = j_q;
    assign addrB = j_q + half[ADDR_W-1:0];
    assign twIdx = twFull[TW_W-1:0];
    assign stage = stage_q;

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT frame sequencer: load natural order, issue all butterflies stage by stage with a
// write-back barrier between stages, then unload in bit-reversed order.
module fft_seq_ctrl
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                bf_valid,
    input  logic                bf_ready,
    output logic [ADDR_W-1:0]   bf_addr_a,
    output logic [ADDR_W-1:0]   bf_addr_b,
    output logic [TW_W-1:0]     bf_tw_idx,
    output logic [STAGE_W-1:0]  bf_stage,
    input  logic                bf_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic                busy,
    output logic                err
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  loadCnt_q, loadCnt_d;
    logic [ADDR_W-1:0]  outCnt_q, outCnt_d;
    logic [ADDR_W-1:0]  outst_q, outst_d;
    logic               err_q, err_d;

    logic               loadHs;
    logic               issueHs;
    logic               outHs;
    logic               clearGen;
    logic               nextStage;
    logic               genLast;
    logic [ADDR_W-1:0]  genA;
    logic [ADDR_W-1:0]  genB;
    logic [TW_W-1:0]    genTw;
    logic [STAGE_W-1:0] genStage;

    fft_bf_addr_gen u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (clearGen),
        .advance     (issueHs),
        .nextStage   (nextStage),
        .addrA       (genA),
        .addrB       (genB),
        .twIdx       (genTw),
        .stage       (genStage),
        .lastInStage (genLast)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LOAD;
            loadCnt_q <= '0;
            outCnt_q  <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            loadCnt_q <= loadCnt_d;
            outCnt_q  <= outCnt_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    assign loadHs  = in_valid & in_ready;
    assign issueHs = bf_valid & bf_ready;
    assign outHs   = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        loadCnt_d = loadCnt_q;
        outCnt_d  = outCnt_q;
        clearGen  = 1'b0;
        nextStage = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (loadHs) begin
                    loadCnt_d = loadCnt_q + ADDR_W'(1);
                    if (loadCnt_q == LAST_ADDR) begin
                        clearGen = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issueHs && genLast) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Barrier: the next stage reads what this stage writes back.
                if (outst_q == '0) begin
                    if (genStage == LAST_STAGE) begin
                        outCnt_d = '0;
                        state_d  = UNLOAD;
                    end else begin
                        nextStage = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            UNLOAD: begin
                if (outHs) begin
                    outCnt_d = outCnt_q + ADDR_W'(1);
                    if (outCnt_q == LAST_ADDR) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (issueHs && !bf_done) begin
            outst_d = outst_q + ADDR_W'(1);
        end else if (!issueHs && bf_done) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - ADDR_W'(1);
            end
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign wr_en     = in_valid & in_ready;
    assign wr_addr   = loadCnt_q;
    assign bf_valid  = (state_q == ISSUE);
    assign bf_addr_a = bf_valid ? genA : '0;
    assign bf_addr_b = bf_valid ? genB : '0;
    assign bf_tw_idx = bf_valid ? genTw : '0;
    assign bf_stage  = bf_valid ? genStage : '0;
    assign out_valid = (state_q == UNLOAD);
    assign out_addr  = bitrev(outCnt_q);
    assign out_last  = out_valid && (outCnt_q == LAST_ADDR);
    assign busy      = (state_q != LOAD);
    assign err       = err_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Randomized bench for fft_seq_ctrl: a frame-level model (loop-generated command list,
// arithmetic bit reversal, outstanding/error bookkeeping) is compared every cycle.
module tb_fft_seq_ctrl;
    import fft_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       bf_valid;
    logic       bf_ready;
    logic [5:0] bf_addr_a;
    logic [5:0] bf_addr_b;
    logic [4:0] bf_tw_idx;
    logic [2:0] bf_stage;
    logic       bf_done;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       err;

    int expA[192];
    int expB[192];
    int expTw[192];
    int expSt[192];
    int expOut[64];

    int vectors = 0;
    int miscompares = 0;

    int loaded, issued, doneCnt, unloaded, outst, framesDone;
    bit errModel;
    int cycle = 0;
    int doneQ[$];
    int inProb, rdyProb, outProb, doneDelay;
    bit injectDone;
    bit checking;
    bit prevStall;
    int prevCmd;

    always #5 clk = ~clk;

    fft_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .bf_tw_idx (bf_tw_idx),
        .bf_stage  (bf_stage),
        .bf_done   (bf_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int inP, input int rdyP, input int outP, input int delay);
        inProb    = inP;
        rdyProb   = rdyP;
        outProb   = outP;
        doneDelay = delay;
    endtask

    task automatic resetModel();
        loaded    = 0;
        issued    = 0;
        doneCnt   = 0;
        unloaded  = 0;
        outst     = 0;
        errModel  = 1'b0;
        prevStall = 1'b0;
        doneQ.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_wr_en"}, int'(wr_en), int'(in_valid));
        checkOutput({tag, "_bf_valid"}, int'(bf_valid), 0);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_out_last"}, int'(out_last), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_err"}, int'(err), 0);
        checkOutput({tag, "_addrs"}, int'({wr_addr, bf_addr_a, bf_addr_b, out_addr}), 0);
        checkOutput({tag, "_tw_stage"}, int'({bf_tw_idx, bf_stage}), 0);
    endtask

    task automatic waitFrame(input int budget);
        int target;
        target = framesDone + 1;
        for (int c = 0; c < budget && framesDone < target; c++) @(posedge clk);
        if (framesDone < target) checkOutput("frame_timeout", framesDone, target);
    endtask

    // Input driver: randomized handshakes, bf_done replayed from the due-cycle queue.
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (!rst) begin
                in_valid  = 1'b0;
                bf_ready  = 1'b0;
                out_ready = 1'b0;
                bf_done   = 1'b0;
            end else begin
                in_valid  = ($urandom_range(99) < inProb);
                bf_ready  = ($urandom_range(99) < rdyProb);
                out_ready = ($urandom_range(99) < outProb);
                if (injectDone) begin
                    bf_done    = 1'b1;
                    injectDone = 1'b0;
                end else if (doneQ.size() > 0 && doneQ[0] <= cycle) begin
                    bf_done = 1'b1;
                    void'(doneQ.pop_front());
                end else begin
                    bf_done = 1'b0;
                end
            end
        end
    end

    // Compare against the model on the falling edge, then fold this cycle's handshakes in.
    always @(negedge clk) begin : cmpProc
        bit inLoad;
        bit legal;
        bit hs;
        bit dn;
        if (checking && rst) begin
            inLoad = (loaded < 64);
            checkOutput("in_ready", int'(in_ready), int'(inLoad));
            checkOutput("wr_en", int'(wr_en), int'(in_valid && inLoad));
            if (inLoad) checkOutput("wr_addr", int'(wr_addr), loaded);
            checkOutput("busy", int'(busy), int'(!inLoad));
            checkOutput("err", int'(err), int'(errModel));
            if (prevStall) begin
                checkOutput("bf_hold_valid", int'(bf_valid), 1);
                checkOutput("bf_hold_cmd", int'({bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage}), prevCmd);
            end
            if (bf_valid) begin
                legal = !inLoad && issued < 192 && doneCnt >= 32 * (issued / 32);
                checkOutput("bf_valid_legal", int'(legal), 1);
                if (issued < 192) begin
                    checkOutput("bf_addr_a", int'(bf_addr_a), expA[issued]);
                    checkOutput("bf_addr_b", int'(bf_addr_b), expB[issued]);
                    checkOutput("bf_tw_idx", int'(bf_tw_idx), expTw[issued]);
                    checkOutput("bf_stage", int'(bf_stage), expSt[issued]);
                end
            end
            if (out_valid) begin
                legal = !inLoad && issued == 192 && outst == 0 && unloaded < 64;
                checkOutput("out_valid_legal", int'(legal), 1);
                if (unloaded < 64) begin
                    checkOutput("out_addr", int'(out_addr), expOut[unloaded]);
                    checkOutput("out_last", int'(out_last), int'(unloaded == 63));
                end
            end else begin
                checkOutput("out_last_idle", int'(out_last), 0);
            end

            hs = bf_valid && bf_ready;
            dn = bf_done;
            prevStall = bf_valid && !bf_ready;
            prevCmd   = int'({bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage});
            if (hs) begin
                issued++;
                doneQ.push_back(cycle + doneDelay);
            end
            if (hs && dn) begin
                doneCnt++;
            end else if (hs) begin
                outst++;
            end else if (dn) begin
                if (outst == 0) begin
                    errModel = 1'b1;
                end else begin
                    outst--;
                    doneCnt++;
                end
            end
            if (in_valid && inLoad) loaded++;
            if (out_valid && out_ready) begin
                unloaded++;
                if (unloaded == 64) begin
                    framesDone++;
                    loaded   = 0;
                    issued   = 0;
                    doneCnt  = 0;
                    unloaded = 0;
                end
            end
        end
    end

    initial begin
        int k;
        int m;
        int r;
        k = 0;
        for (int s = 0; s < 6; s++) begin
            m = 64 >> s;
            for (int i = 0; i < m / 2; i++) begin
                for (int j = i; j < 64; j += m) begin
                    expA[k]  = j;
                    expB[k]  = j + m / 2;
                    expTw[k] = (i << s) % 32;
                    expSt[k] = s;
                    k++;
                end
            end
        end
        for (int c = 0; c < 64; c++) begin
            r = 0;
            for (int b = 0; b < 6; b++) if (((c >> b) & 1) == 1) r += 1 << (5 - b);
            expOut[c] = r;
        end

        checkOutput("model_count", k, 192);
        checkOutput("model_cmd0_b", expB[0], 32);
        checkOutput("model_cmd31", expA[31] * 100 + expTw[31], 3131);
        checkOutput("model_cmd33", expA[33] * 100 + expB[33], 3248);
        checkOutput("model_cmd34", expA[34] * 1000 + expB[34] * 10 + expTw[34], 1172);
        checkOutput("model_cmd191", expA[191] * 100 + expB[191], 6263);
        checkOutput("model_rev", expOut[1] * 10000 + expOut[2] * 100 + expOut[4], 321608);
        checkOutput("model_rev63", expOut[63], 63);

        framesDone = 0;
        injectDone = 1'b0;
        checking   = 1'b0;
        resetModel();
        applyStimulus(100, 100, 100, 1);
        rst       = 1'b0;
        in_valid  = 1'b0;
        bf_ready  = 1'b0;
        out_ready = 1'b0;
        bf_done   = 1'b0;
        #12;
        checkReset("reset");
        @(negedge clk);
        rst      = 1'b1;
        checking = 1'b1;

        $display("[TB] frame 1: always-ready peers");
        waitFrame(3000);

        $display("[TB] frame 2: random stalls, delayed write-back");
        applyStimulus(70, 50, 50, 5);
        waitFrame(3000);

        $display("[TB] spurious bf_done while idle");
        applyStimulus(0, 100, 100, 1);
        @(posedge clk);
        injectDone = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("err_sticky", int'(err), 1);

        $display("[TB] frame 3: reset during stage 3");
        applyStimulus(100, 60, 100, 3);
        for (int c = 0; c < 3000 && issued < 101; c++) @(posedge clk);
        checkOutput("stage3_reached", int'(issued >= 101), 1);
        @(posedge clk);
        #3;
        rst      = 1'b0;
        checking = 1'b0;
        #1;
        checkReset("midframe");
        resetModel();
        repeat (3) @(posedge clk);
        #3;
        rst      = 1'b1;
        checking = 1'b1;

        $display("[TB] frame 4: full frame after reset");
        applyStimulus(80, 50, 50, 2);
        waitFrame(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
Sequencer for the 64-point in-place radix-2 DIF fixed-point FFT of the one-seg receive chain. It does not touch sample data. It generates addresses, twiddle indices and handshakes for three phases of each frame:
- loading a frame into the sample RAM,
- issuing all 192 butterflies to the butterfly unit, stage by stage, with a completion barrier between stages,
- unloading results in bit-reversed read order.

Parameters:
LOG2N, 6, log2 of FFT length; N = 1<<LOG2N points, N/2 butterflies per stage, LOG2N stages.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  input sample present
in_ready  out  1  controller accepts sample (LOAD state)
wr_en  out  1  sample RAM write strobe = in_valid & in_ready
wr_addr  out  LOG2N  sample RAM write address (natural order)
bf_valid  out  1  butterfly command valid
bf_ready  in  1  butterfly unit accepts command
bf_addr_a  out  LOG2N  upper operand address j
bf_addr_b  out  LOG2N  lower operand address k = j + mh
bf_tw_idx  out  LOG2N-1  twiddle ROM index
bf_stage  out  3  current stage 0..LOG2N-1
bf_done  in  1  one-cycle pulse per completed butterfly write-back
out_valid  out  1  result read command valid
out_ready  in  1  consumer accepts
out_addr  out  LOG2N  result RAM read address, bit-reversed
out_last  out  1  marks final unload beat
busy  out  1  high in ISSUE, DRAIN, UNLOAD
err  out  1  sticky: bf_done received with zero outstanding

Behaviour:
- Reset values: state=LOAD; all counters 0; bf_valid=out_valid=out_last=busy=err=0; in_ready=1; all addresses and bf_stage 0.
- All outputs are registered or pure decodes of state/counters. No combinational path from any input to any output except wr_en.
- LOAD:
  - in_ready=1; wr_addr=load_cnt.
  - On accept: load_cnt++.
  - Accept with load_cnt==N-1 → load_cnt=0, stage=0, i=0, j=0, go to ISSUE next cycle.
- ISSUE:
  - bf_valid=1; m=N>>stage, mh=m>>1.
  - Outputs: addr_a=j, addr_b=j+mh, tw_idx=i<<stage (truncated to LOG2N-1 bits), bf_stage=stage.
  - Commands hold stable while bf_valid & !bf_ready.
  - On handshake:
    - j+m<N → j+=m.
    - Else if i+1<mh → i++, j=i+1.
    - Else (last butterfly of stage) → go to DRAIN.
  - Order: i outer, j inner. Exactly N/2 handshakes per stage.
- DRAIN:
  - bf_valid=0.
  - When outstanding==0 (combinational check this cycle):
    - stage<LOG2N-1 → stage++, i=0, j=0, back to ISSUE.
    - Otherwise → UNLOAD, out_cnt=0.
- Outstanding counter (LOG2N bits):
  - +1 on issue handshake; −1 on bf_done; both in the same cycle → unchanged.
  - bf_done while outstanding==0 → counter held at 0, err set (cleared only by reset).
  - bf_done arriving in LOAD/UNLOAD follows the same rules.
- UNLOAD:
  - out_valid=1; out_addr=bitrev(out_cnt); out_last=(out_cnt==N-1).
  - On handshake: out_cnt++.
  - Handshake on the last beat → LOAD, with in_ready=1 the next cycle.
- in_ready=0 outside LOAD. in_valid is ignored there and no write occurs.
- Reset mid-frame: all state is lost immediately and the controller returns to LOAD. Partially processed RAM contents are not its concern.
- Minimum frame latency, with always-ready peers and 1-cycle bf_done: last load accept → first out_valid = LOG2N*(N/2) issue cycles + LOG2N drain cycles + 1.

Decomposition:
- Shared package fft_pkg holds: LOG2N/N constants, state enum (LOAD, ISSUE, DRAIN, UNLOAD), the widths of address, twiddle index and stage, and a bitrev function.
- One natural sub-module: fft_bf_addr_gen. It holds the stage/i/j counters and produces addr_a, addr_b, tw_idx and last_in_stage from an advance strobe.
- Top level holds the FSM, outstanding counter, load and unload counters.

Test Plan:
1. Reset, then 64 accepted samples with in_valid held → wr_addr 0..63; in_ready falls the cycle after the 64th accept; bf_valid rises with (a=0, b=32, tw=0, stage=0).
2. Stage order, always-ready: stage 0 gives (0,32,0),(1,33,1)…(31,63,31). Stage 1 starts (0,16,0),(32,48,0),(1,17,2),(33,49,2). Stage 5 gives (0,1,0),(2,3,0)…(62,63,0). Total 192 commands.
3. Barrier: bf_done delayed 5 cycles per command and bf_ready toggled randomly → no stage s+1 command before the 32nd bf_done of stage s; commands stable while stalled; err stays 0.
4. Simultaneous issue and bf_done in the same cycle → outstanding unchanged. Extra bf_done at outstanding 0 → err=1, counter stays 0.
5. Unload with out_ready 50% duty → out_addr 0,32,16,48,8,40…63; out_last only on the 64th beat; in_ready=1 the cycle after.
6. rst asserted during stage 3 issue → outputs at reset values asynchronously; a new 64-sample frame then processes correctly end to end.
